// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage pipelined bitwise logic unit with a valid/ready
// stream interface, an internal accumulator for iterative reductions, and
// registered result flags (zero / all-ones / parity) aligned with y.
module logic_unit_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ones,
  output logic             parity
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTA = 3'b110,
    OP_PASB = 3'b111
  } op_t;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] s1_r;
  logic             s1_valid;
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] r;
  logic             s2_adv;
  logic             s1_adv;
  logic             accept;

  // Handshake: S2 drains when empty or consumed, S1 moves when S2 moves,
  // and a new beat is taken whenever S1 is empty or emptying this cycle.
  always_comb begin
    s2_adv   = !out_valid || out_ready;
    s1_adv   = s1_valid && s2_adv;
    in_ready = !s1_valid || s1_adv;
    accept   = in_valid && in_ready;
  end

  // Operand select and the eight logic operations; a clear coinciding with
  // an accumulate beat makes the beat see a zero accumulator.
  always_comb begin
    a_eff = a;
    if (acc_mode) begin
      a_eff = acc_clr ? '0 : acc;
    end
    r = '0;
    case (op_t'(op))
      OP_AND:  r = a_eff & b;
      OP_OR:   r = a_eff | b;
      OP_XOR:  r = a_eff ^ b;
      OP_NAND: r = ~(a_eff & b);
      OP_NOR:  r = ~(a_eff | b);
      OP_XNOR: r = ~(a_eff ^ b);
      OP_NOTA: r = ~a_eff;
      OP_PASB: r = b;
      default: r = '0;
    endcase
  end

  // Stage 1: capture the freshly computed result on accept, otherwise
  // empty out once the held result has moved into stage 2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_r     <= r;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: output register plus flags, frozen while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      zero      <= 1'b1;
      ones      <= 1'b0;
      parity    <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        y      <= s1_r;
        zero   <= (s1_r == '0);
        ones   <= (s1_r == '1);
        parity <= ^s1_r;
      end
    end
  end

  // Accumulator is written in the same edge that loads stage 1, so
  // back-to-back accumulate beats always see the newest value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (accept && acc_mode) begin
      acc <= r;
    end else if (acc_clr) begin
      acc <= '0;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed and randomized checks of logic_unit_pipe at
// WIDTH=4, 1 and 32 against a queue-based reference model.
module tb_logic_unit_pipe;

  logic clk;
  logic reset_n;

  logic [2:0]       in_valid_v;
  logic [2:0]       in_ready_v;
  logic [2:0][31:0] a_v;
  logic [2:0][31:0] b_v;
  logic [2:0][2:0]  op_v;
  logic [2:0]       acc_mode_v;
  logic [2:0]       acc_clr_v;
  logic [2:0]       out_valid_v;
  logic [2:0]       out_ready_v;
  logic [2:0]       zero_v;
  logic [2:0]       ones_v;
  logic [2:0]       parity_v;
  logic [3:0]       y4;
  logic [0:0]       y1;
  logic [31:0]      y32;

  int testCount = 0;
  int failCount = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic [31:0] log0[$];
  logic [31:0] macc[3];
  logic        lastAcc[3];
  logic        lastXfer[3];

  logic [3:0] opTable[8];

  logic_unit_pipe #(.WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_v[0][3:0]), .b(b_v[0][3:0]), .op(op_v[0]),
    .acc_mode(acc_mode_v[0]), .acc_clr(acc_clr_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .y(y4), .zero(zero_v[0]), .ones(ones_v[0]), .parity(parity_v[0])
  );

  logic_unit_pipe #(.WIDTH(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_v[1][0:0]), .b(b_v[1][0:0]), .op(op_v[1]),
    .acc_mode(acc_mode_v[1]), .acc_clr(acc_clr_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .y(y1), .zero(zero_v[1]), .ones(ones_v[1]), .parity(parity_v[1])
  );

  logic_unit_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a_v[2]), .b(b_v[2]), .op(op_v[2]),
    .acc_mode(acc_mode_v[2]), .acc_clr(acc_clr_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .y(y32), .zero(zero_v[2]), .ones(ones_v[2]), .parity(parity_v[2])
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] maskOf(input int k);
    case (k)
      0:       return 32'h0000_000F;
      1:       return 32'h0000_0001;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] getY(input int k);
    case (k)
      0:       return {28'b0, y4};
      1:       return {31'b0, y1};
      default: return y32;
    endcase
  endfunction

  // Reference operation table written straight from the operation list.
  function automatic logic [31:0] refOp(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] z, input logic [31:0] m);
    logic [31:0] res;
    case (o)
      3'd0: res = x & z;
      3'd1: res = x | z;
      3'd2: res = x ^ z;
      3'd3: res = ~(x & z);
      3'd4: res = ~(x | z);
      3'd5: res = ~(x ^ z);
      3'd6: res = ~x;
      default: res = z;
    endcase
    return res & m;
  endfunction

  function automatic int sizeQ(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [31:0] frontQ(input int k);
    case (k)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic popQ(input int k);
    case (k)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic pushQ(input int k, input logic [31:0] v);
    case (k)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock for all three units: check whatever is on the outputs against
  // the model, update the model with the handshakes, then advance.
  task automatic stepClock();
    logic [31:0] obsY, expV, aEff, res, m;
    #1;
    for (int k = 0; k < 3; k++) begin
      m = maskOf(k);
      lastAcc[k]  = in_valid_v[k] && in_ready_v[k];
      lastXfer[k] = out_valid_v[k] && out_ready_v[k];
      obsY = getY(k);
      if (out_valid_v[k]) begin
        if (sizeQ(k) == 0) begin
          checkOutput("stale_beat", 32'd1, 32'd0);
        end else begin
          expV = frontQ(k);
          checkOutput("y", obsY, expV);
          checkOutput("zero", {31'b0, zero_v[k]}, {31'b0, expV == 32'd0});
          checkOutput("ones", {31'b0, ones_v[k]}, {31'b0, expV == m});
          checkOutput("parity", {31'b0, parity_v[k]}, {31'b0, ^expV});
        end
      end
      if (lastXfer[k] && sizeQ(k) != 0) begin
        if (k == 0) log0.push_back(obsY);
        popQ(k);
      end
      if (lastAcc[k]) begin
        aEff = acc_mode_v[k] ? (acc_clr_v[k] ? 32'd0 : macc[k]) : (a_v[k] & m);
        res  = refOp(op_v[k], aEff, b_v[k] & m, m);
        pushQ(k, res);
        if (acc_mode_v[k]) macc[k] = res;
        else if (acc_clr_v[k]) macc[k] = 32'd0;
      end else if (acc_clr_v[k]) begin
        macc[k] = 32'd0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic vld, input logic [2:0] o, input logic [31:0] av,
                               input logic [31:0] bv, input logic am, input logic ac);
    in_valid_v[0] = vld;
    op_v[0]       = o;
    a_v[0]        = av;
    b_v[0]        = bv;
    acc_mode_v[0] = am;
    acc_clr_v[0]  = ac;
  endtask

  // Hold a beat on the 4-bit unit until it is taken, bounded.
  task automatic sendBeat(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input logic am, input logic ac);
    logic done;
    done = 1'b0;
    applyStimulus(1'b1, o, av, bv, am, ac);
    for (int i = 0; i < 20 && !done; i++) begin
      stepClock();
      done = lastAcc[0];
    end
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) stepClock();
  endtask

  task automatic clearModel();
    q0.delete();
    q1.delete();
    q2.delete();
    for (int k = 0; k < 3; k++) macc[k] = 32'd0;
  endtask

  function automatic logic [31:0] logTail(input int n);
    if (log0.size() > n) return log0[log0.size() - 1 - n];
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    int idx;
    int base;
    opTable = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b0011, 4'b1010};
    in_valid_v = '0; a_v = '0; b_v = '0; op_v = '0;
    acc_mode_v = '0; acc_clr_v = '0; out_ready_v = 3'b111;
    clearModel();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_out_valid", {31'b0, out_valid_v[0]}, 32'd0);
    checkOutput("rst_y", {28'b0, y4}, 32'd0);
    checkOutput("rst_zero", {31'b0, zero_v[0]}, 32'd1);
    checkOutput("rst_ones", {31'b0, ones_v[0]}, 32'd0);
    checkOutput("rst_parity", {31'b0, parity_v[0]}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", {31'b0, in_ready_v[0]}, 32'd1);
    @(negedge clk);

    // Every op in isolation, checking two-edge latency and the result table.
    for (int i = 0; i < 8; i++) begin
      sendBeat(3'(i), 32'hC, 32'hA, 1'b0, 1'b0);
      checkOutput("lat_early", {31'b0, out_valid_v[0]}, 32'd0);
      stepClock();
      checkOutput("lat_valid", {31'b0, out_valid_v[0]}, 32'd1);
      checkOutput("op_table", {28'b0, y4}, {28'b0, opTable[i]});
    end
    idle(3);

    // Backpressure: only two beats fit, output holds, then drains gap-free.
    out_ready_v[0] = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 3'(idx), 32'hC, 32'hA, 1'b0, 1'b0);
      stepClock();
      if (lastAcc[0]) idx++;
    end
    checkOutput("bp_accepts", 32'(idx), 32'd2);
    checkOutput("bp_in_ready", {31'b0, in_ready_v[0]}, 32'd0);
    checkOutput("bp_hold_y", {28'b0, y4}, 32'b1000);
    out_ready_v[0] = 1'b1;
    base = log0.size();
    for (int c = 0; c < 4; c++) begin
      if (idx < 4) applyStimulus(1'b1, 3'(idx), 32'hC, 32'hA, 1'b0, 1'b0);
      else applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      stepClock();
      if (c == 0) checkOutput("bp_recover_accept", {31'b0, lastAcc[0]}, 32'd1);
      if (lastAcc[0]) idx++;
      checkOutput("bp_no_gap", {31'b0, lastXfer[0]}, 32'd1);
    end
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    idle(2);
    checkOutput("bp_order0", (log0.size() > base) ? log0[base] : 32'hDEAD_BEEF, 32'b1000);
    checkOutput("bp_order3", (log0.size() > base + 3) ? log0[base + 3] : 32'hDEAD_BEEF, 32'b0111);

    // Accumulator reduction, back to back, then probe with OR 0.
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    stepClock();
    applyStimulus(1'b1, 3'd1, 32'd0, 32'b0001, 1'b1, 1'b0);
    stepClock();
    applyStimulus(1'b1, 3'd1, 32'd0, 32'b0100, 1'b1, 1'b0);
    stepClock();
    applyStimulus(1'b1, 3'd2, 32'd0, 32'b1111, 1'b1, 1'b0);
    stepClock();
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    idle(3);
    checkOutput("acc_y0", logTail(2), 32'b0001);
    checkOutput("acc_y1", logTail(1), 32'b0101);
    checkOutput("acc_y2", logTail(0), 32'b1010);
    sendBeat(3'd1, 32'd0, 32'd0, 1'b1, 1'b0);
    idle(3);
    checkOutput("acc_value", logTail(0), 32'b1010);

    // Clear coinciding with an accumulate beat.
    sendBeat(3'd7, 32'd0, 32'b1111, 1'b1, 1'b0);
    sendBeat(3'd1, 32'd0, 32'b0010, 1'b1, 1'b1);
    idle(3);
    checkOutput("clracc_y", logTail(0), 32'b0010);
    sendBeat(3'd1, 32'd0, 32'd0, 1'b1, 1'b0);
    idle(3);
    checkOutput("clracc_acc", logTail(0), 32'b0010);

    // Reset mid-stream with both stages full.
    out_ready_v[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 3'd7, 32'd0, 32'(c + 5), 1'b0, 1'b0);
      stepClock();
    end
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    clearModel();
    checkOutput("mid_rst_valid", {31'b0, out_valid_v[0]}, 32'd0);
    checkOutput("mid_rst_y", {28'b0, y4}, 32'd0);
    checkOutput("mid_rst_zero", {31'b0, zero_v[0]}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready_v[0] = 1'b1;
    #1;
    checkOutput("mid_rst_in_ready", {31'b0, in_ready_v[0]}, 32'd1);
    @(negedge clk);
    idle(4);
    sendBeat(3'd1, 32'd0, 32'd0, 1'b1, 1'b0);
    idle(3);
    checkOutput("mid_rst_acc", logTail(0), 32'd0);

    // Randomized traffic on all three widths.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 3; k++) begin
        in_valid_v[k]  = ($urandom % 4) != 0;
        out_ready_v[k] = ($urandom % 3) != 0;
        a_v[k]         = $urandom;
        b_v[k]         = $urandom;
        op_v[k]        = 3'($urandom % 8);
        acc_mode_v[k]  = ($urandom % 3) == 0;
        acc_clr_v[k]   = ($urandom % 16) == 0;
      end
      stepClock();
    end
    in_valid_v = '0;
    acc_clr_v = '0;
    out_ready_v = 3'b111;
    idle(5);
    for (int k = 0; k < 3; k++) checkOutput("drain_empty", 32'(sizeQ(k)), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, pipelined bitwise logic unit with a valid/ready stream interface, eight selectable operations, an internal accumulator mode for iterative reductions, and registered result flags. It sits between an operand source and a result consumer in the datapath, and replaces fixed-width, unregistered gate banks. Throughput is one operation per cycle under no backpressure.

## Interface
- WIDTH, 4, operand/result width in bits (≥1)
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit accepts beat this cycle
- a  input  WIDTH  operand A (ignored when acc_mode=1)
- b  input  WIDTH  operand B
- op  input  3  operation select, sampled with the beat
- acc_mode  input  1  beat uses accumulator as A and writes result back to it
- acc_clr  input  1  clear accumulator (independent of handshake)
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result
- y  output  WIDTH  result
- zero  output  1  y == 0
- ones  output  1  y == all ones
- parity  output  1  XOR of all bits of y

## Operation
- Ops: 000 A&B, 001 A|B, 010 A^B, 011 ~(A&B), 100 ~(A|B), 101 ~(A^B), 110 ~A, 111 B. All results are exactly WIDTH bits; there is no extension or truncation.
- Accept: a beat transfers when in_valid && in_ready.
- Stage 1 (S1): on accept, compute the result r = op(A_eff, b), where A_eff = acc_mode ? acc : a. Register r and set s1_valid.
- Stage 2 (S2): register y = r and compute zero, ones and parity from r. Set out_valid.
- Flow control:
  - S2 advances when !out_valid || out_ready.
  - S1 advances into S2 when s1_valid && S2 advances.
  - in_ready = !s1_valid || (S1 advancing). in_ready is combinational from out_ready and the internal state, with no dependence on in_valid.
- Accumulator `acc` (WIDTH bits):
  - On an accepted beat with acc_mode=1, acc <= r in the same edge that loads S1.
  - Back-to-back accumulate beats therefore always see the latest value, with no forwarding hazard.
  - Beats with acc_mode=0 leave acc untouched.
- acc_clr:
  - acc_clr=1 with no accumulate accept: acc <= 0 on the next edge.
  - acc_clr=1 with an accumulate accept in the same cycle: the beat uses A_eff = 0, and acc <= op(0, b).
  - acc_clr never affects S1 or S2 contents.
- Reset (reset_n low, asynchronous):
  - s1_valid=0, out_valid=0, y=0, zero=1, ones=0, parity=0, acc=0.
  - in_ready reads 1 once reset_n is high.
  - Any in-flight beats are discarded. No output toggles after deassertion until a new accept.

## Timing
- Latency: a beat accepted at edge N produces out_valid=1 with its y after edge N+1, i.e. two edges from presentation to output.
- Throughput: one beat per cycle while out_ready=1.
- Backpressure:
  - While out_valid && !out_ready, y and the flags hold stable.
  - S1 holds one further beat.
  - in_ready drops only when both stages are full and out_ready=0.
- Ordering: results leave in strict acceptance order. No beat is dropped or duplicated.
- Stall recovery: when out_ready rises with both stages full, S2 takes S1 and S1 accepts a new beat on the same edge. There is no bubble.
- Flags are aligned with y in the same cycle.

## Test plan
- Reset and idle: assert reset_n=0 mid-stream with both stages full, then release.
  - Required: out_valid=0, y=0, zero=1, acc=0, in_ready=1.
  - No stale beat emerges afterwards.
- All ops at WIDTH=4 with a=4'b1100, b=4'b1010 and out_ready=1.
  - Required y in order 1000, 1110, 0110, 0111, 0001, 1001, 0011, 1010, each two edges after its accept.
  - zero/ones/parity must match: e.g. XOR gives parity 0; OR gives ones 0.
- Backpressure: stream 4 beats with out_ready=0.
  - in_ready must fall after 2 accepts, and y must hold the first result.
  - Then raise out_ready: all 4 results arrive in order with no gaps.
- Accumulator: pulse acc_clr, then accumulate beats OR 0001, OR 0100, XOR 1111, back to back.
  - Required y = 0001, 0101, 1010, and acc = 1010.
- Simultaneous clear and accumulate: with acc=1111, send acc_mode=1, op=OR, b=0010, acc_clr=1.
  - Required y = 0010 and acc = 0010.
- Parameter sweep: WIDTH=1 and WIDTH=32 with random ops, random valid and random out_ready.
  - Scoreboard compares results against a golden model, with zero mismatches and no lost beats.
